// File: rtl/ring_phase_monitor.sv
// Phase monitor for a one-hot right-rotating ring register.
// Tracks hot position, locks on clean rotation, counts revolutions.
module ring_phase_monitor #(
  parameter int WIDTH    = 6,
  parameter int IDX_W    = 3,
  parameter int REV_W    = 8,
  parameter int SYNC_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             locked,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int GW = (SYNC_CNT > 1) ? $clog2(SYNC_CNT) : 1;
  localparam logic [GW-1:0] LAST = GW'(SYNC_CNT - 1);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);

  state_t st_q, st_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0] good_q, good_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic vld_q, vld_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic pulse_q, pulse_d;
  logic sticky_q, sticky_d;

  logic [WIDTH-1:0] expected;
  logic [IDX_W-1:0] enc;
  logic onehot;
  logic step_ok;
  logic wrap;

  // Lowest set bit wins; only used when the sample is one-hot.
  always_comb begin
    enc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ring_in[i]) enc = IDX_W'(i);
    end
  end

  assign onehot   = (ring_in != '0) &&
                    ((ring_in & (ring_in - 1'b1)) == '0);
  assign expected = {prev_q[0], prev_q[WIDTH-1:1]};
  assign step_ok  = onehot && (ring_in == expected);
  assign wrap     = (idx_q == '0) && (enc == TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      rev_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      rev_q    <= rev_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    prev_d   = prev_q;
    good_d   = good_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    rev_d    = rev_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    if (clr_err) begin
      st_d     = IDLE;
      sticky_d = 1'b0;
      rev_d    = '0;
      vld_d    = 1'b0;
      good_d   = '0;
    end else if (ring_vld) begin
      unique case (st_q)
        IDLE: begin
          if (onehot) begin
            prev_d = ring_in;
            idx_d  = enc;
            vld_d  = 1'b1;
            good_d = '0;
            st_d   = SYNC;
          end else begin
            vld_d  = 1'b0;
          end
        end
        SYNC: begin
          unique case (1'b1)
            step_ok: begin
              prev_d = ring_in;
              idx_d  = enc;
              if (good_q == LAST) begin
                good_d = '0;
                st_d   = LOCK;
              end else begin
                good_d = good_q + GW'(1);
              end
            end
            onehot && !step_ok: begin
              prev_d = ring_in;
              idx_d  = enc;
              good_d = '0;
            end
            !onehot: begin
              st_d   = IDLE;
              vld_d  = 1'b0;
              good_d = '0;
            end
          endcase
        end
        LOCK: begin
          if (step_ok) begin
            prev_d = ring_in;
            idx_d  = enc;
            if (wrap) rev_d = rev_q + REV_W'(1);
          end else begin
            st_d     = FAULT;
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
          end
        end
        FAULT: begin
        end
      endcase
    end
  end

  assign idx        = idx_q;
  assign idx_vld    = vld_q;
  assign locked     = (st_q == LOCK);
  assign rev_cnt    = rev_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign state      = st_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed plan steps plus random
// traffic against an index-arithmetic reference model.
module tb_ring_phase_monitor;

  localparam int W  = 6;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ring_in;
  logic       ring_vld;
  logic       clr_err;
  logic [2:0] idx;
  logic       idx_vld;
  logic       locked;
  logic [7:0] rev_cnt;
  logic       err_pulse;
  logic       err_sticky;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  int m_state, m_idx, m_vld, m_good, m_rev, m_pulse, m_sticky;

  ring_phase_monitor #(
    .WIDTH(6), .IDX_W(3), .REV_W(8), .SYNC_CNT(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ring_in(ring_in),
    .ring_vld(ring_vld),
    .clr_err(clr_err),
    .idx(idx),
    .idx_vld(idx_vld),
    .locked(locked),
    .rev_cnt(rev_cnt),
    .err_pulse(err_pulse),
    .err_sticky(err_sticky),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_vld = 0; m_good = 0;
    m_rev = 0; m_pulse = 0; m_sticky = 0;
  endtask

  // Model works on phase numbers: a good step moves index i to (i+W-1)%W.
  task automatic model(input logic [5:0] r, input bit v, input bit c);
    bit oh;
    int ni;
    oh = ($countones(r) == 1);
    ni = oh ? $clog2(r) : -1;
    m_pulse = 0;
    if (c) begin
      m_state = 0; m_sticky = 0; m_rev = 0; m_vld = 0; m_good = 0;
    end else if (v) begin
      case (m_state)
        0: if (oh) begin
             m_idx = ni; m_vld = 1; m_good = 0; m_state = 1;
           end else m_vld = 0;
        1: if (!oh) begin
             m_state = 0; m_vld = 0; m_good = 0;
           end else begin
             if (ni == (m_idx + W - 1) % W) begin
               m_good++;
               if (m_good == SC) begin m_state = 2; m_good = 0; end
             end else m_good = 0;
             m_idx = ni;
           end
        2: if (oh && ni == (m_idx + W - 1) % W) begin
             if (m_idx == 0) m_rev = (m_rev + 1) % 256;
             m_idx = ni;
           end else begin
             m_state = 3; m_pulse = 1; m_sticky = 1;
           end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(state),      32'(m_state));
    chk({tag, ".idx"},    32'(idx),        32'(m_idx));
    chk({tag, ".vld"},    32'(idx_vld),    32'(m_vld));
    chk({tag, ".locked"}, 32'(locked),     32'(m_state == 2));
    chk({tag, ".rev"},    32'(rev_cnt),    32'(m_rev));
    chk({tag, ".pulse"},  32'(err_pulse),  32'(m_pulse));
    chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic step(input string tag, input logic [5:0] r,
                      input bit v, input bit c);
    ring_in = r; ring_vld = v; clr_err = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    check_all(tag);
    ring_vld = 1'b0; clr_err = 1'b0;
  endtask

  task automatic lock_seq(input string tag);
    step(tag, 6'b000001, 1, 0);
    step(tag, 6'b100000, 1, 0);
    step(tag, 6'b010000, 1, 0);
  endtask

  initial begin
    int src;
    logic [5:0] r;
    bit v, c;
    reset = 1'b1; ring_in = '0; ring_vld = 1'b0; clr_err = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #14 reset = 1'b0;

    step("s1", 6'b000001, 1, 0);
    chk("s1.sync", 32'(state), 32'd1);
    step("s2", 6'b100000, 1, 0);
    chk("s2.sync", 32'(state), 32'd1);
    step("s3", 6'b010000, 1, 0);
    chk("s3.idx4", 32'(idx), 32'd4);
    chk("s3.lock", 32'(locked), 32'd1);

    step("rot", 6'b001000, 1, 0);
    step("rot", 6'b000100, 1, 0);
    step("rot", 6'b000010, 1, 0);
    step("rot", 6'b000001, 1, 0);
    chk("rot.rev0", 32'(rev_cnt), 32'd0);
    step("rot", 6'b100000, 1, 0);
    chk("rot.rev1", 32'(rev_cnt), 32'd1);
    chk("rot.idx5", 32'(idx), 32'd5);
    step("rot", 6'b010000, 1, 0);
    step("rot", 6'b001000, 1, 0);

    step("skip", 6'b000010, 1, 0);
    chk("skip.fault", 32'(state), 32'd3);
    chk("skip.pulse", 32'(err_pulse), 32'd1);
    chk("skip.idx3", 32'(idx), 32'd3);
    step("skip2", 6'b000100, 1, 0);
    chk("skip2.pulse", 32'(err_pulse), 32'd0);
    chk("skip2.sticky", 32'(err_sticky), 32'd1);
    step("skip3", 6'b000000, 0, 0);

    step("clr", 6'b000001, 1, 1);
    chk("clr.idle", 32'(state), 32'd0);
    chk("clr.sticky", 32'(err_sticky), 32'd0);
    chk("clr.vld", 32'(idx_vld), 32'd0);

    step("idle0", 6'b000000, 1, 0);
    step("idlem", 6'b011000, 1, 0);
    chk("idlem.err", 32'(err_sticky), 32'd0);

    lock_seq("l2");
    step("zero", 6'b000000, 1, 0);
    chk("zero.sticky", 32'(err_sticky), 32'd1);
    step("clr2", 6'b000000, 0, 1);
    lock_seq("l3");
    step("multi", 6'b011000, 1, 0);
    chk("multi.sticky", 32'(err_sticky), 32'd1);
    step("clr3", 6'b000000, 0, 1);

    lock_seq("l4");
    src = 4;
    for (int i = 0; i < 29; i++) begin
      src = (src + W - 1) % W;
      r = 6'(1 << src);
      step("rev", r, 1, 0);
    end
    chk("rev5", 32'(rev_cnt), 32'd5);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    #2 reset = 1'b0;
    step("post", 6'b000100, 1, 0);
    chk("post.sync", 32'(state), 32'd1);

    src = 2;
    for (int i = 0; i < 800; i++) begin
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (v && $urandom_range(0, 99) < 85) begin
        src = (src + W - 1) % W;
        r = 6'(1 << src);
      end else begin
        r = 6'($urandom);
      end
      step("rnd", r, v, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
